// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS frequency meter and its divider.
package dds_pkg;

  localparam int DDS_K_W   = 32;
  localparam int DDS_CNT_W = 24;

  // 2^K_W, the dividend that turns a period into a tuning word
  localparam logic [DDS_K_W:0] DDS_FULL_SCALE = {1'b1, {DDS_K_W{1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    DIVIDE
  } fm_state_t;

endpackage

// File: rtl/dds_freq_meter_if.sv
// Signal bundle between the frequency meter and its user: enable and input wave in, tuning word out.
interface dds_freq_meter_if
  import dds_pkg::*;
#(
  parameter int K_W = DDS_K_W
);

  logic           en;
  logic           sig_in;
  logic [K_W-1:0] K_out;
  logic           K_valid;
  logic           busy;
  logic           timeout;

  modport master (
    output en,
    output sig_in,
    input  K_out,
    input  K_valid,
    input  busy,
    input  timeout
  );

  modport slave (
    input  en,
    input  sig_in,
    output K_out,
    output K_valid,
    output busy,
    output timeout
  );

endinterface

// File: rtl/dds_div_seq.sv
// Sequential restoring divider: one quotient bit per cycle, ITER cycles from start to done.
// The dividend bits above ITER must be smaller than the divisor so the quotient fits in ITER bits.
module dds_div_seq #(
  parameter int DVD_W = 33,
  parameter int DVS_W = 24,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [ITER-1:0]  quotient,
  output logic             done
);

  localparam int CW = $clog2(ITER + 1);

  logic [DVS_W-1:0] rem_q, rem_d;
  logic [ITER-1:0]  shf_q, shf_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    left_q, left_d;
  logic             run_q, run_d;
  logic             done_q, done_d;

  // Shift in the next dividend bit, subtract when it fits; the quotient bit
  // replaces the consumed dividend bit at the bottom of the shift register.
  function automatic logic [DVS_W+ITER-1:0] div_step(
    input logic [DVS_W-1:0] rem,
    input logic [ITER-1:0]  shf,
    input logic [DVS_W-1:0] dvs
  );
    logic [DVS_W:0] trial;
    logic [DVS_W:0] diff;
    trial = {rem, shf[ITER-1]};
    diff  = trial - {1'b0, dvs};
    if (trial >= {1'b0, dvs})
      return {diff[DVS_W-1:0], shf[ITER-2:0], 1'b1};
    else
      return {trial[DVS_W-1:0], shf[ITER-2:0], 1'b0};
  endfunction

  // The first iteration runs on the start edge itself.
  always_comb begin
    rem_d  = rem_q;
    shf_d  = shf_q;
    dvs_d  = dvs_q;
    left_d = left_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start) begin
      {rem_d, shf_d} = div_step(DVS_W'(dividend >> ITER), dividend[ITER-1:0], divisor);
      dvs_d  = divisor;
      left_d = CW'(ITER - 1);
      run_d  = 1'b1;
    end else if (run_q) begin
      {rem_d, shf_d} = div_step(rem_q, shf_q, dvs_q);
      left_d = left_q - CW'(1);
      if (left_q == CW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      shf_q  <= '0;
      dvs_q  <= '0;
      left_q <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      shf_q  <= shf_d;
      dvs_q  <= dvs_d;
      left_q <= left_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient = shf_q;
  assign done     = done_q;

endmodule

// File: rtl/dds_freq_meter.sv
// Measures the period of sig_in in clk cycles and produces the DDS tuning word K = 2^K_W / period.
// Define DDS_FM_AVG_EN to average over four consecutive periods (dividing 2^(K_W+2) by their sum).
module dds_freq_meter
  import dds_pkg::*;
#(
  parameter int          K_W        = DDS_K_W,
  parameter int          CNT_W      = DDS_CNT_W,
  parameter int unsigned MAX_PERIOD = 32'h00FF_FFFF
) (
  input  logic            clk,
  input  logic            rst_n,
  dds_freq_meter_if.slave bus
);

`ifdef DDS_FM_AVG_EN
  localparam int EXT = 2;
`else
  localparam int EXT = 0;
`endif
  localparam int DVS_W = CNT_W + EXT;
  localparam int ITER  = K_W + EXT;
  localparam int DVD_W = ITER + 1;
  localparam logic [DVD_W-1:0] FULL    = {1'b1, {ITER{1'b0}}};
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  fm_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [K_W-1:0]   k_out_q;
  logic             k_valid_q;
  logic             timeout_q;
  logic             last_per;
  logic [DVS_W-1:0] div_dvs;
  logic             div_start;
  logic [ITER-1:0]  div_quo;
  logic             div_done;

  // sig_in is asynchronous: two flops to resolve metastability, a third for the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

`ifdef DDS_FM_AVG_EN
  logic [DVS_W-1:0] sum_q;
  logic [DVS_W-1:0] sum_next;
  logic [1:0]       nper_q;

  assign sum_next = sum_q + DVS_W'(cnt_q);
  assign last_per = (nper_q == 2'd3);
  assign div_dvs  = sum_next;
`else
  assign last_per = 1'b1;
  assign div_dvs  = cnt_q;
`endif

  assign div_start = (state_q == MEASURE) && bus.en && rise && last_per;

  dds_div_seq #(
    .DVD_W (DVD_W),
    .DVS_W (DVS_W),
    .ITER  (ITER)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (FULL),
    .divisor  (div_dvs),
    .quotient (div_quo),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      k_out_q   <= '0;
      k_valid_q <= 1'b0;
      timeout_q <= 1'b0;
`ifdef DDS_FM_AVG_EN
      sum_q     <= '0;
      nper_q    <= '0;
`endif
    end else begin
      k_valid_q <= 1'b0;
      if (!bus.en) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (rise) begin
              state_q <= MEASURE;
              cnt_q   <= CNT_W'(1);
`ifdef DDS_FM_AVG_EN
              sum_q   <= '0;
              nper_q  <= '0;
`endif
            end
          end
          MEASURE: begin
            // A rise coinciding with the limit still closes a valid period.
            if (rise) begin
              cnt_q <= CNT_W'(1);
`ifdef DDS_FM_AVG_EN
              sum_q  <= sum_next;
              nper_q <= nper_q + 2'd1;
`endif
              if (last_per) state_q <= DIVIDE;
            end else if (cnt_q == MAX_CNT) begin
              k_out_q   <= '0;
              timeout_q <= 1'b1;
              k_valid_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          DIVIDE: begin
            if (div_done) begin
              k_out_q   <= div_quo[K_W-1:0];
              k_valid_q <= 1'b1;
              timeout_q <= 1'b0;
              state_q   <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.K_out   = k_out_q;
  assign bus.K_valid = k_valid_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = (state_q != IDLE);

endmodule
